// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: control-bus bit positions, ALU operation codes,
// opcode match patterns and the branch condition code used by B.cond.
package legv8_pkg;

    localparam int CTRL_W       = 11;
    localparam int CTRL_FLAGUP  = 0;
    localparam int CTRL_REG2LOC = 1;
    localparam int CTRL_BRTAKEN = 2;
    localparam int CTRL_UNCONDB = 3;
    localparam int CTRL_MEMREAD = 4;
    localparam int CTRL_MEM2REG = 5;
    localparam int CTRL_MEMWR   = 6;
    localparam int CTRL_ALUSRC  = 7;
    localparam int CTRL_REGWR   = 8;
    localparam int CTRL_SHIFT   = 9;
    localparam int CTRL_IMMSEL  = 10;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [2:0] {
        ALU_PASSB = 3'b000,
        ALU_ADD   = 3'b010,
        ALU_SUB   = 3'b011,
        ALU_AND   = 3'b100,
        ALU_ORR   = 3'b101,
        ALU_EOR   = 3'b110
    } alu_op_e;

    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_EOR   = 11'b11001010000;
    localparam logic [10:0] OP_LSR   = 11'b11010011010;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;

    localparam logic [4:0]  COND_LT  = 5'b01011;

    // Signed "less than" from a {N,Z,V,C} flag nibble.
    function automatic logic cond_lt(input logic [3:0] fl);
        return fl[FLAG_N] ^ fl[FLAG_V];
    endfunction

endpackage

// File: rtl/legv8_exec_ctrl_if.sv
// ID/EX control bus between the datapath (master) and the execute controller (slave).
interface legv8_exec_ctrl_if #(
    parameter int DW = 64
);
    logic [31:0]   instr;
    logic [DW-1:0] pc_id;
    logic          db_zero;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [10:0]   ctrl_id;
    logic [2:0]    alu_op_id;
    logic [DW-1:0] branch_target;
    logic [DW-1:0] alu_result;
    logic [3:0]    flags_ex;
    logic [3:0]    flags;

    modport master (
        output instr, pc_id, db_zero, op_a, op_b,
        input  ctrl_id, alu_op_id, branch_target, alu_result, flags_ex, flags
    );

    modport slave (
        input  instr, pc_id, db_zero, op_a, op_b,
        output ctrl_id, alu_op_id, branch_target, alu_result, flags_ex, flags
    );
endinterface

// File: rtl/legv8_exec_ctrl_adder.sv
// DW-bit adder with carry-in, shared by the ALU and the branch-target path.
module legv8_exec_ctrl_adder #(
    parameter int DW = 64
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          cin_i,
    output logic [DW-1:0] sum_o,
    output logic          carry_out_o,
    output logic          overflow_o
);
    logic [DW:0] full_s;

    // Wide add; overflow when like-signed operands give an opposite-signed sum.
    always_comb begin
        full_s      = {1'b0, a_i} + {1'b0, b_i} + {{DW{1'b0}}, cin_i};
        sum_o       = full_s[DW-1:0];
        carry_out_o = full_s[DW];
        overflow_o  = (a_i[DW-1] == b_i[DW-1]) && (full_s[DW-1] != a_i[DW-1]);
    end
endmodule

// File: rtl/legv8_exec_ctrl.sv
// LEGv8 ID-stage decoder, branch-target adder and EX-stage ALU with flag register.
// Define LEGV8_FLAG_FWD_EN to forward EX-stage flags into B.cond decode.
module legv8_exec_ctrl
    import legv8_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic              clk,
    input  logic              reset,
    legv8_exec_ctrl_if.slave  bus
);
    logic [CTRL_W-1:0] ctrl_s;
    logic [2:0]        op_s;
    logic [3:0]        dec_flags_s;
    logic [DW-1:0]     off_s;
    logic [DW-1:0]     off_sh_s;
    logic [DW-1:0]     br_sum_s;

    logic [2:0]        alu_op_q, alu_op_d;
    logic              flag_up_q, flag_up_d;
    logic [3:0]        flags_q, flags_d;

    logic [DW-1:0]     b_eff_s;
    logic              cin_s;
    logic [DW-1:0]     sum_s;
    logic              cout_s;
    logic              ovf_s;
    logic [DW-1:0]     res_s;
    logic              c_s;
    logic              v_s;
    logic [3:0]        flags_ex_s;

    // Flags seen by B.cond in decode.
    always_comb begin
`ifdef LEGV8_FLAG_FWD_EN
        if (flag_up_q) begin
            dec_flags_s = flags_ex_s;
        end else begin
            dec_flags_s = flags_q;
        end
`else
        dec_flags_s = flags_q;
`endif
    end

    // Instruction decode: opcode match to control bus and ALU operation.
    always_comb begin
        ctrl_s = {CTRL_W{1'b0}};
        op_s   = ALU_PASSB;
        if (bus.instr[31:22] == OP_ADDI) begin
            ctrl_s[CTRL_REGWR]  = 1'b1;
            ctrl_s[CTRL_ALUSRC] = 1'b1;
            ctrl_s[CTRL_IMMSEL] = 1'b1;
            op_s                = ALU_ADD;
        end else if ((bus.instr[31:21] == OP_ADDS) || (bus.instr[31:21] == OP_SUBS)) begin
            ctrl_s[CTRL_REGWR]   = 1'b1;
            ctrl_s[CTRL_REG2LOC] = 1'b1;
            ctrl_s[CTRL_FLAGUP]  = 1'b1;
            op_s                 = (bus.instr[31:21] == OP_SUBS) ? ALU_SUB : ALU_ADD;
        end else if ((bus.instr[31:21] == OP_AND) || (bus.instr[31:21] == OP_EOR)) begin
            ctrl_s[CTRL_REGWR]   = 1'b1;
            ctrl_s[CTRL_REG2LOC] = 1'b1;
            op_s                 = (bus.instr[31:21] == OP_EOR) ? ALU_EOR : ALU_AND;
        end else if (bus.instr[31:21] == OP_LSR) begin
            ctrl_s[CTRL_REGWR] = 1'b1;
            ctrl_s[CTRL_SHIFT] = 1'b1;
            op_s               = ALU_PASSB;
        end else if (bus.instr[31:21] == OP_LDUR) begin
            ctrl_s[CTRL_REGWR]   = 1'b1;
            ctrl_s[CTRL_ALUSRC]  = 1'b1;
            ctrl_s[CTRL_MEMREAD] = 1'b1;
            ctrl_s[CTRL_MEM2REG] = 1'b1;
            op_s                 = ALU_ADD;
        end else if (bus.instr[31:21] == OP_STUR) begin
            ctrl_s[CTRL_MEMWR]  = 1'b1;
            ctrl_s[CTRL_ALUSRC] = 1'b1;
            op_s                = ALU_ADD;
        end else if (bus.instr[31:26] == OP_B) begin
            ctrl_s[CTRL_BRTAKEN] = 1'b1;
            ctrl_s[CTRL_UNCONDB] = 1'b1;
        end else if (bus.instr[31:24] == OP_BCOND) begin
            if (bus.instr[4:0] == COND_LT) begin
                ctrl_s[CTRL_BRTAKEN] = cond_lt(dec_flags_s);
            end else begin
                ctrl_s = {CTRL_W{1'b0}};
            end
        end else if (bus.instr[31:24] == OP_CBZ) begin
            ctrl_s[CTRL_BRTAKEN] = bus.db_zero;
        end else begin
            ctrl_s = {CTRL_W{1'b0}};
        end
    end

    // Word-scaled branch offset: imm26 for B, imm19 for conditional forms.
    always_comb begin
        if (ctrl_s[CTRL_UNCONDB]) begin
            off_s = {{(DW-26){bus.instr[25]}}, bus.instr[25:0]};
        end else begin
            off_s = {{(DW-19){bus.instr[23]}}, bus.instr[23:5]};
        end
        off_sh_s = {off_s[DW-3:0], 2'b00};
    end

    legv8_exec_ctrl_adder #(.DW(DW)) u_br_add (
        .a_i         (bus.pc_id),
        .b_i         (off_sh_s),
        .cin_i       (1'b0),
        .sum_o       (br_sum_s),
        .carry_out_o (),
        .overflow_o  ()
    );

    // Subtraction runs through the same adder as A + ~B + 1.
    always_comb begin
        if (alu_op_q == ALU_SUB) begin
            b_eff_s = ~bus.op_b;
            cin_s   = 1'b1;
        end else begin
            b_eff_s = bus.op_b;
            cin_s   = 1'b0;
        end
    end

    legv8_exec_ctrl_adder #(.DW(DW)) u_alu_add (
        .a_i         (bus.op_a),
        .b_i         (b_eff_s),
        .cin_i       (cin_s),
        .sum_o       (sum_s),
        .carry_out_o (cout_s),
        .overflow_o  (ovf_s)
    );

    // EX-stage ALU result and flags from the registered operation.
    always_comb begin
        c_s = 1'b0;
        v_s = 1'b0;
        case (alu_op_q)
            ALU_PASSB: res_s = bus.op_b;
            ALU_ADD, ALU_SUB: begin
                res_s = sum_s;
                c_s   = cout_s;
                v_s   = ovf_s;
            end
            ALU_AND:   res_s = bus.op_a & bus.op_b;
            ALU_ORR:   res_s = bus.op_a | bus.op_b;
            ALU_EOR:   res_s = bus.op_a ^ bus.op_b;
            default:   res_s = {DW{1'b0}};
        endcase
        flags_ex_s = {res_s[DW-1], (res_s == {DW{1'b0}}), v_s, c_s};
    end

    // Next state of the ID/EX pipeline registers and committed flags.
    always_comb begin
        alu_op_d  = op_s;
        flag_up_d = ctrl_s[CTRL_FLAGUP];
        if (flag_up_q) begin
            flags_d = flags_ex_s;
        end else begin
            flags_d = flags_q;
        end
    end

    // State registers; reset wins over a pending flag update.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_op_q  <= 3'b000;
            flag_up_q <= 1'b0;
            flags_q   <= 4'b0000;
        end else begin
            alu_op_q  <= alu_op_d;
            flag_up_q <= flag_up_d;
            flags_q   <= flags_d;
        end
    end

    assign bus.ctrl_id       = ctrl_s;
    assign bus.alu_op_id     = op_s;
    assign bus.branch_target = br_sum_s;
    assign bus.alu_result    = res_s;
    assign bus.flags_ex      = flags_ex_s;
    assign bus.flags         = flags_q;

endmodule

// File: tb/tb_legv8_exec_ctrl.sv
// Randomized self-checking bench for legv8_exec_ctrl against a behavioural model.
module tb_legv8_exec_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    legv8_exec_ctrl_if #(.DW(64)) bus ();
    legv8_exec_ctrl #(.DW(64)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    logic [2:0]  m_op;
    logic        m_fu;
    logic [3:0]  m_flags;
    bit          m_valid = 1'b0;

    logic [10:0] e_ctrl;
    logic [2:0]  e_op;
    logic [63:0] e_tgt;
    logic [63:0] e_res;
    logic [3:0]  e_fex;
    logic        e_rst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void alu_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                      output logic [63:0] r, output logic [3:0] f);
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: r = b;
            3'd2: begin r = a + b; c = (r < a);  v = (a[63] == b[63]) && (r[63] != a[63]); end
            3'd3: begin r = a - b; c = (a >= b); v = (a[63] != b[63]) && (r[63] != a[63]); end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = 64'd0;
        endcase
        f = {r[63], (r == 64'd0), v, c};
    endfunction

    function automatic void dec_model(input logic [31:0] i, input logic [63:0] pc, input logic dbz,
                                      input logic [3:0] fl, output logic [10:0] c, output logic [2:0] op,
                                      output logic [63:0] tgt);
        logic signed [25:0] o26;
        logic signed [18:0] o19;
        longint s;
        c  = 11'h000;
        op = 3'd0;
        if      (i[31:22] == 10'h244) begin c = 11'h580; op = 3'd2; end
        else if (i[31:21] == 11'h558) begin c = 11'h103; op = 3'd2; end
        else if (i[31:21] == 11'h758) begin c = 11'h103; op = 3'd3; end
        else if (i[31:21] == 11'h450) begin c = 11'h102; op = 3'd4; end
        else if (i[31:21] == 11'h650) begin c = 11'h102; op = 3'd6; end
        else if (i[31:21] == 11'h69A) begin c = 11'h300; op = 3'd0; end
        else if (i[31:21] == 11'h7C2) begin c = 11'h1B0; op = 3'd2; end
        else if (i[31:21] == 11'h7C0) begin c = 11'h0C0; op = 3'd2; end
        else if (i[31:26] == 6'h05)   begin c = 11'h00C; end
        else if (i[31:24] == 8'h54)   begin c = ((i[4:0] == 5'h0B) && (fl[3] != fl[1])) ? 11'h004 : 11'h000; end
        else if (i[31:24] == 8'hB4)   begin c = dbz ? 11'h004 : 11'h000; end
        o26 = i[25:0];
        o19 = i[23:5];
        if (c[3]) s = o26; else s = o19;
        tgt = pc + 64'(s * 4);
    endfunction

    task automatic drive(input logic [31:0] i, input logic [63:0] pc, input logic dbz,
                         input logic [63:0] a, input logic [63:0] b, input logic rst);
        logic [3:0] dfl;
        @(negedge clk);
        reset = rst;
        bus.instr = i; bus.pc_id = pc; bus.db_zero = dbz; bus.op_a = a; bus.op_b = b;
        alu_model(m_op, a, b, e_res, e_fex);
`ifdef LEGV8_FLAG_FWD_EN
        dfl = m_fu ? e_fex : m_flags;
`else
        dfl = m_flags;
`endif
        dec_model(i, pc, dbz, dfl, e_ctrl, e_op, e_tgt);
        e_rst = rst;
        #1;
        if (m_valid) begin
            chk("ctrl_id", 64'(bus.ctrl_id), 64'(e_ctrl));
            chk("alu_op_id", 64'(bus.alu_op_id), 64'(e_op));
            chk("branch_target", bus.branch_target, e_tgt);
            chk("alu_result", bus.alu_result, e_res);
            chk("flags_ex", 64'(bus.flags_ex), 64'(e_fex));
            chk("flags", 64'(bus.flags), 64'(m_flags));
        end
    endtask

    task automatic commit();
        @(posedge clk);
        if (e_rst) begin
            m_op = 3'd0; m_fu = 1'b0; m_flags = 4'd0;
        end else begin
            if (m_fu) m_flags = e_fex;
            m_op = e_op;
            m_fu = e_ctrl[0];
        end
        m_valid = 1'b1;
    endtask

    task automatic step(input logic [31:0] i, input logic [63:0] pc, input logic dbz,
                        input logic [63:0] a, input logic [63:0] b, input logic rst);
        drive(i, pc, dbz, a, b, rst);
        commit();
    endtask

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 13))
            0:  r[31:22] = 10'h244;
            1:  r[31:21] = 11'h558;
            2:  r[31:21] = 11'h758;
            3:  r[31:21] = 11'h450;
            4:  r[31:21] = 11'h650;
            5:  r[31:21] = 11'h69A;
            6:  r[31:21] = 11'h7C2;
            7:  r[31:21] = 11'h7C0;
            8:  r[31:26] = 6'h05;
            9, 10: begin
                r[31:24] = 8'h54;
                if ($urandom_range(0, 3) != 0) r[4:0] = 5'h0B;
            end
            11: r[31:24] = 8'hB4;
            12: r[31:21] = ($urandom_range(0, 1) == 0) ? 11'h558 : 11'h758;
            default: ;
        endcase
        return r;
    endfunction

    localparam logic [31:0] I_ADDS = 32'hAB02_0020;
    localparam logic [31:0] I_SUBS = 32'hEB00_0000;
    localparam logic [31:0] I_BLT  = 32'h5400_000B;

    initial begin
        logic [63:0] a, b;
        reset = 1'b1;
        bus.instr = 32'd0; bus.pc_id = 64'd0; bus.db_zero = 1'b0; bus.op_a = 64'd0; bus.op_b = 64'd0;
        step(32'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1);

        drive(32'd0, 64'd0, 1'b0, 64'h1234, 64'h55AA, 1'b0);
        chk("lit_reset_passb", bus.alu_result, 64'h55AA);
        chk("lit_reset_flags", 64'(bus.flags), 64'h0);
        commit();

        step(I_ADDS, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(32'd0, 64'd0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        chk("lit_adds_result", bus.alu_result, 64'h8000_0000_0000_0000);
        chk("lit_adds_flags_ex", 64'(bus.flags_ex), 64'hA);
        commit();
        drive(32'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("lit_adds_flags", 64'(bus.flags), 64'hA);
        commit();

        step(I_SUBS, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(I_BLT, 64'd0, 1'b0, 64'd5, 64'd5, 1'b0);
        chk("lit_subs_result", bus.alu_result, 64'd0);
        chk("lit_subs_flags_ex", 64'(bus.flags_ex), 64'h5);
        chk("lit_blt_not_taken", 64'(bus.ctrl_id[2]), 64'd0);
        commit();

        step(I_SUBS, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
        step(32'd0, 64'd0, 1'b0, 64'd3, 64'd5, 1'b0);
        drive(I_BLT, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("lit_blt_taken", 64'(bus.ctrl_id), 64'h004);
        commit();

        drive(32'h17FF_FFFF, 64'h100, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("lit_b_ctrl", 64'(bus.ctrl_id), 64'h00C);
        chk("lit_b_target", bus.branch_target, 64'hFC);
        commit();
        drive(32'hB400_0060, 64'h40, 1'b1, 64'd0, 64'd0, 1'b0);
        chk("lit_cbz_taken", 64'(bus.ctrl_id), 64'h004);
        chk("lit_cbz_target", bus.branch_target, 64'h4C);
        commit();
        drive(32'hB400_0060, 64'h40, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("lit_cbz_not_taken", 64'(bus.ctrl_id), 64'h000);
        commit();
        drive(32'hF840_0000, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("lit_ldur_ctrl", 64'(bus.ctrl_id), 64'h1B0);
        chk("lit_ldur_op", 64'(bus.alu_op_id), 64'h2);
        commit();
        drive(32'hF800_0000, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("lit_stur_ctrl", 64'(bus.ctrl_id), 64'h0C0);
        commit();
        drive(32'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("lit_zero_ctrl", 64'(bus.ctrl_id), 64'h000);
        commit();

        step(32'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1);
        step(I_ADDS, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
        step(32'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1);
        drive(32'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("lit_reset_beats_flagup", 64'(bus.flags), 64'h0);
        commit();

        for (int n = 0; n < 600; n++) begin
            a = rnd_op();
            b = ($urandom_range(0, 7) == 0) ? a : rnd_op();
            step(rnd_instr(), {$urandom, $urandom}, 1'($urandom_range(0, 1)), a, b,
                 ($urandom_range(0, 39) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
